// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared datapath widths and EX2 state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int WORD_W    = 16;
  localparam int REG_IDX_W = 4;

  typedef logic [0:0] ex2_state_t;

  localparam ex2_state_t ST_IDLE = 1'b0;
  localparam ex2_state_t ST_BUSY = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ex2_mem_stage.sv
// ============================================================================
// Module : ex2_mem_stage
// Brief  : EX2 stage - branch resolve, dmem req/ack access with timeout,
//          registered writeback bundle and upstream stall.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ex2_mem_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD_W-1:0]    ex2_alu_result,
  input  logic [WORD_W-1:0]    ex2_rs2_data,
  input  logic [WORD_W-1:0]    ex2_branch_target,
  input  logic [REG_IDX_W-1:0] ex2_rd,
  input  logic                 ex2_zero,
  input  logic                 ex2_reg_write,
  input  logic                 ex2_mem_read,
  input  logic                 ex2_mem_write,
  input  logic                 ex2_mem_to_reg,
  input  logic                 ex2_branch,
  input  logic                 ex2_branch_ne,
  input  logic                 dmem_ack,
  input  logic [WORD_W-1:0]    dmem_rdata,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [WORD_W-1:0]    dmem_addr,
  output logic [WORD_W-1:0]    dmem_wdata,
  output logic                 stall,
  output logic                 branch_taken,
  output logic [WORD_W-1:0]    branch_target,
  output logic                 wb_valid,
  output logic                 wb_reg_write,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic [WORD_W-1:0]    wb_data,
  output logic                 mem_fault
);

  localparam logic [7:0] c_timeout_last = 8'(TIMEOUT_CYCLES - 1);

  ex2_state_t r_state;
  logic [7:0] r_cnt;

  logic w_memop;
  logic w_busy;
  logic w_timeout;

  assign w_memop   = ex2_mem_read | ex2_mem_write;
  assign w_busy    = (r_state == ST_BUSY);
  assign w_timeout = w_busy & (r_cnt == c_timeout_last);

  // Ack and timeout both release the pipeline in the cycle they occur.
  assign stall         = w_busy ? (~dmem_ack & ~w_timeout) : w_memop;
  assign branch_taken  = ~w_busy & ex2_branch & (ex2_zero ^ ex2_branch_ne);
  assign branch_target = ex2_branch_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      mem_fault    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_memop) begin
            r_state      <= ST_BUSY;
            r_cnt        <= '0;
            dmem_req     <= 1'b1;
            dmem_we      <= ex2_mem_write & ~ex2_mem_read;
            dmem_addr    <= ex2_alu_result;
            dmem_wdata   <= ex2_rs2_data;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
          end else begin
            wb_valid     <= 1'b1;
            wb_reg_write <= ex2_reg_write;
            wb_rd        <= ex2_rd;
            wb_data      <= ex2_alu_result;
          end
        end
        default: begin
          if (dmem_ack) begin
            r_state      <= ST_IDLE;
            dmem_req     <= 1'b0;
            wb_valid     <= 1'b1;
            wb_reg_write <= ex2_reg_write & ~dmem_we;
            wb_rd        <= ex2_rd;
            wb_data      <= ex2_mem_to_reg ? dmem_rdata : ex2_alu_result;
          end else if (w_timeout) begin
            // Abandoned access retires without touching the register file.
            r_state      <= ST_IDLE;
            dmem_req     <= 1'b0;
            mem_fault    <= 1'b1;
            wb_valid     <= 1'b1;
            wb_reg_write <= 1'b0;
          end else begin
            r_cnt        <= r_cnt + 8'd1;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex2_mem_stage.sv
// ============================================================================
// Module : tb_ex2_mem_stage
// Brief  : Directed vector table plus multi-cycle memory/reset sequences.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ex2_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ex2_alu_result, ex2_rs2_data, ex2_branch_target;
  logic [3:0]  ex2_rd;
  logic        ex2_zero, ex2_reg_write, ex2_mem_read, ex2_mem_write;
  logic        ex2_mem_to_reg, ex2_branch, ex2_branch_ne;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;
  logic        dmem_req, dmem_we, stall, branch_taken, wb_valid, wb_reg_write, mem_fault;
  logic [15:0] dmem_addr, dmem_wdata, branch_target, wb_data;
  logic [3:0]  wb_rd;

  int checks = 0;
  int errors = 0;

  ex2_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex2_alu_result(ex2_alu_result), .ex2_rs2_data(ex2_rs2_data),
    .ex2_branch_target(ex2_branch_target), .ex2_rd(ex2_rd), .ex2_zero(ex2_zero),
    .ex2_reg_write(ex2_reg_write), .ex2_mem_read(ex2_mem_read),
    .ex2_mem_write(ex2_mem_write), .ex2_mem_to_reg(ex2_mem_to_reg),
    .ex2_branch(ex2_branch), .ex2_branch_ne(ex2_branch_ne),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] alu;
    logic [3:0]  rd;
    logic        rw;
    logic        zero;
    logic        br;
    logic        ne;
    logic [15:0] tgt;
    logic        ack;
    logic        exp_taken;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex2_alu_result = '0; ex2_rs2_data = '0; ex2_branch_target = '0; ex2_rd = '0;
    ex2_zero = 0; ex2_reg_write = 0; ex2_mem_read = 0; ex2_mem_write = 0;
    ex2_mem_to_reg = 0; ex2_branch = 0; ex2_branch_ne = 0;
    dmem_ack = 0; dmem_rdata = '0;
  endtask

  task automatic present_load(input logic [15:0] addr, input logic [3:0] rd);
    clear_inputs();
    ex2_mem_read = 1; ex2_mem_to_reg = 1; ex2_reg_write = 1;
    ex2_alu_result = addr; ex2_rd = rd;
  endtask

  initial begin
    int n;
    //              alu       rd  rw zero br ne tgt       ack taken
    vecs[0] = '{16'h1234, 4'd3,  1, 0,   0, 0, 16'h0000, 0, 0};
    vecs[1] = '{16'h0000, 4'd0,  0, 1,   1, 0, 16'h0100, 0, 1};
    vecs[2] = '{16'h0001, 4'd1,  0, 1,   1, 1, 16'h0180, 0, 0};
    vecs[3] = '{16'h0002, 4'd2,  0, 0,   1, 1, 16'h0200, 0, 1};
    vecs[4] = '{16'h0003, 4'd4,  1, 0,   1, 0, 16'h0300, 0, 0};
    vecs[5] = '{16'hFFFF, 4'd15, 1, 0,   0, 0, 16'h0000, 1, 0};

    clear_inputs();
    rst_n = 0;
    #12;
    chk("reset_wb_valid", wb_valid, 0);
    chk("reset_dmem_req", dmem_req, 0);
    chk("reset_wb_data", wb_data, 0);
    chk("reset_mem_fault", mem_fault, 0);
    chk("reset_stall", stall, 0);
    step();
    rst_n = 1;

    // ALU ops and branches in IDLE; an ack in IDLE must be ignored.
    foreach (vecs[i]) begin
      ex2_alu_result = vecs[i].alu; ex2_rd = vecs[i].rd; ex2_reg_write = vecs[i].rw;
      ex2_zero = vecs[i].zero; ex2_branch = vecs[i].br; ex2_branch_ne = vecs[i].ne;
      ex2_branch_target = vecs[i].tgt; dmem_ack = vecs[i].ack; dmem_rdata = 16'hDEAD;
      #1;
      chk($sformatf("v%0d_taken", i), branch_taken, vecs[i].exp_taken);
      chk($sformatf("v%0d_target", i), branch_target, vecs[i].tgt);
      chk($sformatf("v%0d_stall", i), stall, 0);
      step();
      chk($sformatf("v%0d_wb_valid", i), wb_valid, 1);
      chk($sformatf("v%0d_wb_rw", i), wb_reg_write, vecs[i].rw);
      chk($sformatf("v%0d_wb_rd", i), wb_rd, vecs[i].rd);
      chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].alu);
      chk($sformatf("v%0d_req", i), dmem_req, 0);
    end

    // Load acked two cycles after req.
    present_load(16'h0040, 4'd5);
    #1 chk("ld_stall_c1", stall, 1);
    step();
    chk("ld_req", dmem_req, 1);
    chk("ld_we", dmem_we, 0);
    chk("ld_addr", dmem_addr, 16'h0040);
    chk("ld_bubble", wb_valid, 0);
    chk("ld_stall_c2", stall, 1);
    step();
    chk("ld_stall_c3", stall, 1);
    step();
    dmem_ack = 1; dmem_rdata = 16'hBEEF;
    ex2_branch = 1; ex2_zero = 1;
    #1;
    chk("ld_stall_ack", stall, 0);
    chk("busy_branch", branch_taken, 0);
    step();
    clear_inputs();
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_wb_rw", wb_reg_write, 1);
    chk("ld_wb_rd", wb_rd, 5);
    chk("ld_wb_data", wb_data, 16'hBEEF);
    chk("ld_req_drop", dmem_req, 0);

    // Store acked in the first BUSY cycle; reg_write must be masked.
    ex2_mem_write = 1; ex2_reg_write = 1; ex2_rs2_data = 16'hA5A5;
    ex2_alu_result = 16'h0080; ex2_rd = 4'd7;
    step();
    chk("st_we", dmem_we, 1);
    chk("st_wdata", dmem_wdata, 16'hA5A5);
    chk("st_addr", dmem_addr, 16'h0080);
    dmem_ack = 1;
    #1 chk("st_stall_ack", stall, 0);
    step();
    clear_inputs();
    chk("st_wb_valid", wb_valid, 1);
    chk("st_wb_rw", wb_reg_write, 0);
    chk("st_req_drop", dmem_req, 0);

    // Timeout: ack never comes; req must stay high exactly 4 cycles.
    present_load(16'h0050, 4'd8);
    step();
    n = 0;
    while (dmem_req && n < 20) begin
      if (n == 3) chk("to_stall_last", stall, 0);
      n++;
      step();
    end
    clear_inputs();
    chk("to_req_cycles", n, 4);
    chk("to_fault", mem_fault, 1);
    chk("to_wb_valid", wb_valid, 1);
    chk("to_wb_rw", wb_reg_write, 0);
    step();
    chk("to_fault_sticky", mem_fault, 1);

    // Reset in the middle of an access.
    present_load(16'h0060, 4'd9);
    step();
    chk("rst_pre_req", dmem_req, 1);
    #2;
    rst_n = 0;
    clear_inputs();
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_fault", mem_fault, 0);
    step();
    rst_n = 1;
    ex2_alu_result = 16'h5A5A; ex2_rd = 4'd2; ex2_reg_write = 1;
    step();
    clear_inputs();
    chk("post_rst_wb_valid", wb_valid, 1);
    chk("post_rst_wb_data", wb_data, 16'h5A5A);
    chk("post_rst_wb_rd", wb_rd, 2);

    // Ack coincides with the timeout cycle: normal completion, no fault.
    present_load(16'h0044, 4'd6);
    step();
    step();
    step();
    step();
    chk("ackto_req", dmem_req, 1);
    dmem_ack = 1; dmem_rdata = 16'h1357;
    #1 chk("ackto_stall", stall, 0);
    step();
    clear_inputs();
    chk("ackto_wb_data", wb_data, 16'h1357);
    chk("ackto_wb_rw", wb_reg_write, 1);
    chk("ackto_fault", mem_fault, 0);
    chk("ackto_req_drop", dmem_req, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex2_mem_stage.md
Name: ex2_mem_stage

Overview:
- Consumer end of the EX1/EX2 pipeline register. It takes the latched ex2_* data and control and resolves branches.
- Runs data-memory loads/stores over a req/ack handshake, with a bounded wait.
- Produces the registered writeback bundle.
- Drives stall, which freezes PC, IF/ID, ID/EX1 and EX1/EX2 (the enable on those registers) while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 15, maximum BUSY cycles waiting for dmem_ack before aborting. Legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ex2_alu_result  input  16  ALU result; also the memory word address
- ex2_rs2_data  input  16  store data
- ex2_branch_target  input  16  branch destination
- ex2_rd  input  4  destination register
- ex2_zero  input  1  ALU zero flag
- ex2_reg_write, ex2_mem_read, ex2_mem_write, ex2_mem_to_reg, ex2_branch, ex2_branch_ne  input  1 each  control from EX1/EX2
- dmem_ack  input  1  memory completion, one-cycle pulse
- dmem_rdata  input  16  read data, valid when dmem_ack=1
- dmem_req  output  1  access request, registered
- dmem_we  output  1  1=store, 0=load, registered
- dmem_addr  output  16  registered address
- dmem_wdata  output  16  registered store data
- stall  output  1  freeze upstream stages (combinational)
- branch_taken  output  1  redirect PC / flush younger stages (combinational)
- branch_target  output  16  redirect PC value (combinational)
- wb_valid  output  1  writeback bundle valid, registered
- wb_reg_write  output  1  register-file write enable, registered
- wb_rd  output  4  writeback register index, registered
- wb_data  output  16  writeback data, registered
- mem_fault  output  1  sticky flag: a timeout occurred

Behaviour:
- Reset (rst_n=0, async):
  - All registered outputs go to 0, state goes to IDLE, the timeout counter clears, mem_fault clears.
  - Reset during BUSY drops dmem_req immediately.
- Define memop = ex2_mem_read | ex2_mem_write. If both are set, the access is a read (dmem_we=0).
- States: IDLE and BUSY.
- IDLE, no memop:
  - Next edge: wb_valid<=1, wb_reg_write<=ex2_reg_write, wb_rd<=ex2_rd, wb_data<=ex2_alu_result. Latency is 1 cycle.
  - stall=0.
- IDLE, memop:
  - stall=1.
  - Next edge: dmem_req<=1, dmem_we<=ex2_mem_write&~ex2_mem_read, dmem_addr<=ex2_alu_result, dmem_wdata<=ex2_rs2_data, counter<=0, state<=BUSY.
  - wb_valid<=0 and wb_reg_write<=0 (bubble).
- BUSY:
  - dmem_req/we/addr/wdata are held stable.
  - stall = ~dmem_ack & ~timeout, where timeout = (counter==TIMEOUT_CYCLES-1).
- BUSY with dmem_ack=1, next edge:
  - state<=IDLE, dmem_req<=0, wb_valid<=1, wb_rd<=ex2_rd.
  - wb_reg_write<=ex2_reg_write & ~dmem_we.
  - wb_data<= ex2_mem_to_reg ? dmem_rdata : ex2_alu_result.
  - stall=0 in the ack cycle, so upstream advances on that same edge.
- BUSY, no ack, not timeout: counter increments, wb_valid<=0, wb_reg_write<=0.
- BUSY, timeout with no ack in the same cycle:
  - Next edge: state<=IDLE, dmem_req<=0, mem_fault<=1 (sticky until reset).
  - wb_valid<=1, wb_reg_write<=0: the instruction retires with no register write.
  - stall=0 that cycle.
- Ack and timeout in the same cycle: ack wins, fault is not set.
- dmem_ack while in IDLE is ignored.
- Branch:
  - branch_taken = (state==IDLE) & ex2_branch & (ex2_zero ^ ex2_branch_ne). BEQ is taken on zero; BNE is taken on ~zero.
  - branch_target = ex2_branch_target.
  - A branch with memop set is illegal; the branch is still evaluated and the access proceeds.
- Counter width is 8 bits. It never wraps, because the exit at TIMEOUT_CYCLES-1 occurs first.

Decomposition:
- Shared package cpu_pkg holds WORD_W=16, REG_IDX_W=4, and the ex2_state_t encoding (IDLE=1'b0, BUSY=1'b1).
- No sub-module; the block is a single module.

Test Plan:
- ALU op: alu_result=16'h1234, rd=3, reg_write=1, no memop -> one edge later wb_valid=1, wb_reg_write=1, wb_rd=3, wb_data=16'h1234; stall is never asserted.
- Load: mem_read=1, mem_to_reg=1, alu_result=16'h0040, ack two cycles after req with rdata=16'hBEEF:
  - dmem_req=1, we=0, addr=16'h0040 on the edge after the load is presented.
  - stall=1 for 3 cycles.
  - Edge after ack: wb_data=16'hBEEF, wb_reg_write=1.
- Store: mem_write=1, rs2_data=16'hA5A5, ack in the first BUSY cycle -> dmem_we=1, dmem_wdata=16'hA5A5; retires with wb_valid=1, wb_reg_write=0; stall=0 in the ack cycle.
- Timeout with TIMEOUT_CYCLES=4 and ack never asserted -> dmem_req high for exactly 4 cycles, then mem_fault=1 (held), wb_reg_write=0. A next load acked at the same cycle as the timeout -> normal completion, mem_fault stays as it was.
- Branch:
  - branch=1, ne=0, zero=1, target=16'h0100 -> branch_taken=1, branch_target=16'h0100.
  - branch=1, ne=1, zero=1 -> branch_taken=0.
  - Any branch while BUSY -> branch_taken=0.
- Reset mid-BUSY: drop rst_n while dmem_req=1 -> dmem_req, stall, wb_valid and mem_fault are 0 immediately; after release, an ALU op completes with 1-cycle latency.
